// File: rtl/demux_1to4.sv
// demux_1to4: registered 1-to-4 demultiplexer with a one-hot valid strobe.
// HOLD_UNSEL picks whether unselected outputs clear to zero or keep their value.
module demux_1to4 #(
    parameter int WIDTH      = 1,
    parameter bit HOLD_UNSEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       vld
);
    logic [3:0]       hit;
    logic [WIDTH-1:0] y [4];
    // hit is the one-hot write mask for this edge; all-zero when disabled
    assign hit = en ? 4'b0001 << sel : 4'b0000;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < 4; i++) y[i] <= '0;
        end else begin
            vld <= hit;
            for (int i = 0; i < 4; i++) y[i] <= hit[i] ? in : (HOLD_UNSEL ? y[i] : '0);
        end
    end
    assign y0 = y[0];
    assign y1 = y[1];
    assign y2 = y[2];
    assign y3 = y[3];
endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: drives three demux_1to4 builds (W1 clear, W8 clear, W8 hold) from
// shared stimulus and checks them against a per-edge behavioural model.
module tb_demux_1to4;
    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [7:0] in;
    logic [1:0] sel;
    logic       n_y0, n_y1, n_y2, n_y3;
    logic [7:0] c_y0, c_y1, c_y2, c_y3, h_y0, h_y1, h_y2, h_y3;
    logic [3:0] n_vld, c_vld, h_vld;
    logic [7:0] mc [4];
    logic [7:0] mh [4];
    logic [3:0] mv;
    logic [79:0] got_all;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1to4 #(.WIDTH(1), .HOLD_UNSEL(1'b0)) u_n (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in[0]), .sel(sel),
        .y0(n_y0), .y1(n_y1), .y2(n_y2), .y3(n_y3), .vld(n_vld));
    demux_1to4 #(.WIDTH(8), .HOLD_UNSEL(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in), .sel(sel),
        .y0(c_y0), .y1(c_y1), .y2(c_y2), .y3(c_y3), .vld(c_vld));
    demux_1to4 #(.WIDTH(8), .HOLD_UNSEL(1'b1)) u_h (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in), .sel(sel),
        .y0(h_y0), .y1(h_y1), .y2(h_y2), .y3(h_y3), .vld(h_vld));

    assign got_all = {n_y3, n_y2, n_y1, n_y0, n_vld,
                      c_y3, c_y2, c_y1, c_y0, c_vld,
                      h_y3, h_y2, h_y1, h_y0, h_vld};

    function automatic logic [79:0] exp_all();
        return {mc[3][0], mc[2][0], mc[1][0], mc[0][0], mv,
                mc[3], mc[2], mc[1], mc[0], mv,
                mh[3], mh[2], mh[1], mh[0], mv};
    endfunction

    // Apply one clock edge with the given inputs and advance the model by the same rules.
    task automatic step(input logic r, input logic e, input logic [7:0] d, input logic [1:0] s);
        rst_n = r; en = e; in = d; sel = s;
        @(posedge clk);
        #1;
        if (!r) begin
            mv = 4'b0000;
            for (int k = 0; k < 4; k++) begin mc[k] = 8'h00; mh[k] = 8'h00; end
        end else if (e) begin
            mv = 4'b0001 << s;
            for (int k = 0; k < 4; k++) mc[k] = (k == int'(s)) ? d : 8'h00;
            mh[s] = d;
        end else begin
            mv = 4'b0000;
            for (int k = 0; k < 4; k++) mc[k] = 8'h00;
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 8'h01, 2'b10);
        step(1'b0, 1'b1, 8'h01, 2'b10);
        checks++;
        if (got_all !== 80'h0) begin
            errors++;
            $display("FAIL reset_clear got=%h want=%h", got_all, 80'h0);
        end
        step(1'b1, 1'b1, 8'h01, 2'b10);
        checks++;
        if (got_all[79:72] !== 8'b0100_0100) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", got_all[79:72], 8'b0100_0100);
        end
        checks++;
        if (got_all !== exp_all()) begin
            errors++;
            $display("FAIL reset_release_model got=%h want=%h", got_all, exp_all());
        end
    endtask

    task automatic test_sel_sweep();
        logic [3:0] oh;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 8'h01, 2'(k));
            oh = 4'b0001 << k;
            checks++;
            if (got_all[79:72] !== {oh, oh}) begin
                errors++;
                $display("FAIL sel_sweep sel=%0d got=%b want=%b", k, got_all[79:72], {oh, oh});
            end
        end
    endtask

    task automatic test_data_zero();
        step(1'b1, 1'b1, 8'hA5, 2'b11);
        checks++;
        if (got_all[71:36] !== {8'hA5, 24'h0, 4'b1000}) begin
            errors++;
            $display("FAIL data_a5 got=%h want=%h", got_all[71:36], {8'hA5, 24'h0, 4'b1000});
        end
        step(1'b1, 1'b1, 8'h00, 2'b11);
        checks++;
        if (got_all[71:36] !== {32'h0, 4'b1000}) begin
            errors++;
            $display("FAIL data_zero got=%h want=%h", got_all[71:36], {32'h0, 4'b1000});
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b0, 8'h00, 2'b00);
        step(1'b1, 1'b1, 8'h11, 2'b00);
        step(1'b1, 1'b1, 8'h22, 2'b01);
        step(1'b1, 1'b1, 8'h33, 2'b10);
        checks++;
        if (got_all[35:0] !== {8'h00, 8'h33, 8'h22, 8'h11, 4'b0100}) begin
            errors++;
            $display("FAIL hold_fill got=%h want=%h", got_all[35:0], {8'h00, 8'h33, 8'h22, 8'h11, 4'b0100});
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'hFF, 2'b11);
            checks++;
            if (got_all[35:0] !== {8'h00, 8'h33, 8'h22, 8'h11, 4'b0000}) begin
                errors++;
                $display("FAIL hold_disabled edge=%0d got=%h want=%h", i, got_all[35:0], {8'h00, 8'h33, 8'h22, 8'h11, 4'b0000});
            end
        end
    endtask

    task automatic test_enable_low();
        step(1'b1, 1'b1, 8'h01, 2'b01);
        checks++;
        if (got_all[79:72] !== 8'b0010_0010) begin
            errors++;
            $display("FAIL en_y1 got=%b want=%b", got_all[79:72], 8'b0010_0010);
        end
        step(1'b1, 1'b0, 8'h01, 2'b01);
        checks++;
        if (got_all[79:36] !== 44'h0) begin
            errors++;
            $display("FAIL en_low got=%h want=%h", got_all[79:36], 44'h0);
        end
        step(1'b1, 1'b1, 8'h5C, 2'b01);
        checks++;
        if (got_all[71:36] !== {16'h0, 8'h5C, 8'h00, 4'b0010}) begin
            errors++;
            $display("FAIL en_resume got=%h want=%h", got_all[71:36], {16'h0, 8'h5C, 8'h00, 4'b0010});
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 8'h01, 2'b00);
        step(1'b1, 1'b1, 8'h01, 2'b01);
        step(1'b0, 1'b1, 8'h01, 2'b10);
        checks++;
        if (got_all !== 80'h0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=%h", got_all, 80'h0);
        end
        step(1'b1, 1'b1, 8'h01, 2'b11);
        checks++;
        if (got_all[79:72] !== 8'b1000_1000) begin
            errors++;
            $display("FAIL reset_mid_resume got=%b want=%b", got_all[79:72], 8'b1000_1000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 2'($urandom));
            checks++;
            if (got_all !== exp_all()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, got_all, exp_all());
            end
            checks++;
            if (!$onehot0(got_all[39:36])) begin
                errors++;
                $display("FAIL random_onehot cyc=%0d got=%b want=onehot0", i, got_all[39:36]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in = 8'h00; sel = 2'b00; mv = 4'b0000;
        for (int k = 0; k < 4; k++) begin mc[k] = 8'h00; mh[k] = 8'h00; end
        @(negedge clk);
        test_reset();
        test_sel_sweep();
        test_data_zero();
        test_hold();
        test_enable_low();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
